// File: rtl/riscv_pkg.sv
// Shared types for the riscv memory stage.
//   mem_size_e  : access width encoding carried from the EXU
//   lsu_state_e : bus-side state of the load/store unit
package riscv_pkg;

  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/riscv_lsu_align.sv
// Byte-lane alignment for the LSU; purely combinational.
//   size_i/offset_i : access width and addr[1:0]
//   unsigned_i      : zero-extend loads instead of sign-extend
//   store_data_i    : rs2 value, replicated onto the lanes as wdata_o
//   rdata_i         : bus read word, extracted/extended into load_data_o
//   be_o            : byte enables for the access
//   misaligned_o    : access crosses its natural alignment
module riscv_lsu_align
  import riscv_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  offset_i,
  input  logic        unsigned_i,
  input  logic [31:0] store_data_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] load_data_o,
  output logic        misaligned_o
);

  logic [31:0] shifted;

  always_comb begin
    // Bring the addressed byte/half down to bit 0.
    shifted      = rdata_i >> {offset_i, 3'b000};
    be_o         = 4'hF;
    wdata_o      = store_data_i;
    load_data_o  = rdata_i;
    misaligned_o = |offset_i;
    case (size_i)
      MEM_BYTE: begin
        be_o         = 4'b0001 << offset_i;
        wdata_o      = {4{store_data_i[7:0]}};
        load_data_o  = {{24{~unsigned_i & shifted[7]}}, shifted[7:0]};
        misaligned_o = 1'b0;
      end
      MEM_HALF: begin
        be_o         = 4'b0011 << offset_i;
        wdata_o      = {2{store_data_i[15:0]}};
        load_data_o  = {{16{~unsigned_i & shifted[15]}}, shifted[15:0]};
        misaligned_o = offset_i[0];
      end
      default: ; // word, and reserved size 3 behaves as word
    endcase
  end

endmodule

// File: rtl/riscv_lsu.sv
// Memory stage between EXU and WBU.
//   EXU side : valid_i/ready_o handshake with pc, rd, alu result / address,
//              store data and memory-op attributes.
//   Data bus : req/gnt for the address phase, rvalid/rdata for load data.
//   WBU side : one-entry output register (valid_o/ready_i) carrying pc, rd,
//              rd_data and the misaligned flag.
//   Hazards  : rd of the instruction still owned by this stage, and a flag
//              while a bus access is in flight.
module riscv_lsu
  import riscv_pkg::*;
(
  input  logic        clk_i,
  input  logic        reset_i,
  output logic        ready_o,
  input  logic        valid_i,
  input  logic [29:0] pc_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] alu_result_i,
  input  logic [31:0] store_data_i,
  input  logic        mem_en_i,
  input  logic        mem_we_i,
  input  logic [1:0]  mem_size_i,
  input  logic        mem_unsigned_i,
  output logic        dbus_req_o,
  output logic [29:0] dbus_addr_o,
  output logic        dbus_we_o,
  output logic [3:0]  dbus_be_o,
  output logic [31:0] dbus_wdata_o,
  input  logic        dbus_gnt_i,
  input  logic        dbus_rvalid_i,
  input  logic [31:0] dbus_rdata_i,
  output logic        valid_o,
  input  logic        ready_i,
  output logic [29:0] pc_o,
  output logic [4:0]  rd_addr_o,
  output logic [31:0] rd_data_o,
  output logic        misaligned_o,
  output logic [4:0]  hz_rd_addr_o,
  output logic        hz_load_pending_o
);

  lsu_state_e  state_q;
  logic [31:0] addr_q, wdata_q, data_o_q;
  logic [29:0] pc_q, pc_o_q;
  logic [4:0]  rd_q, rd_o_q;
  logic [3:0]  be_q;
  logic [1:0]  size_q;
  logic        we_q, uns_q, valid_q, mis_q;

  logic        idle, accept;
  logic [1:0]  al_size, al_off;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;
  logic        al_mis;

  assign idle    = (state_q == IDLE);
  assign ready_o = idle && (!valid_q || ready_i);
  assign accept  = valid_i && ready_o;

  // One aligner serves both paths: in IDLE it sees the incoming instruction
  // (store lanes, misalignment); otherwise the captured access (load extract).
  assign al_size = idle ? mem_size_i : size_q;
  assign al_off  = idle ? alu_result_i[1:0] : addr_q[1:0];

  riscv_lsu_align u_align (
    .size_i       (al_size),
    .offset_i     (al_off),
    .unsigned_i   (uns_q),
    .store_data_i (store_data_i),
    .rdata_i      (dbus_rdata_i),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .load_data_o  (al_load),
    .misaligned_o (al_mis)
  );

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      size_q   <= '0;
      uns_q    <= 1'b0;
      pc_q     <= '0;
      rd_q     <= '0;
      valid_q  <= 1'b0;
      pc_o_q   <= '0;
      rd_o_q   <= '0;
      data_o_q <= '0;
      mis_q    <= 1'b0;
    end else begin
      if (valid_q && ready_i) valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          pc_q <= pc_i;
          rd_q <= rd_addr_i;
          if (!mem_en_i) begin
            valid_q  <= 1'b1;
            pc_o_q   <= pc_i;
            rd_o_q   <= rd_addr_i;
            data_o_q <= alu_result_i;
            mis_q    <= 1'b0;
          end else if (al_mis) begin
            // Never reaches the bus; WBU sees a flagged, non-writing result.
            valid_q  <= 1'b1;
            pc_o_q   <= pc_i;
            rd_o_q   <= '0;
            data_o_q <= '0;
            mis_q    <= 1'b1;
          end else begin
            addr_q  <= alu_result_i;
            we_q    <= mem_we_i;
            be_q    <= al_be;
            wdata_q <= mem_we_i ? al_wdata : 32'h0;
            size_q  <= mem_size_i;
            uns_q   <= mem_unsigned_i;
            state_q <= REQ;
          end
        end
        // REQ/RESP are entered only with the output register free (ready_o
        // required it), so completions below never clobber a pending result.
        REQ: if (dbus_gnt_i) begin
          if (we_q) begin
            valid_q  <= 1'b1;
            pc_o_q   <= pc_q;
            rd_o_q   <= '0;
            data_o_q <= '0;
            mis_q    <= 1'b0;
            state_q  <= IDLE;
          end else begin
            state_q <= RESP;
          end
        end
        RESP: if (dbus_rvalid_i) begin
          valid_q  <= 1'b1;
          pc_o_q   <= pc_q;
          rd_o_q   <= rd_q;
          data_o_q <= al_load;
          mis_q    <= 1'b0;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dbus_req_o        = (state_q == REQ);
  assign dbus_addr_o       = addr_q[31:2];
  assign dbus_we_o         = we_q;
  assign dbus_be_o         = be_q;
  assign dbus_wdata_o      = wdata_q;
  assign valid_o           = valid_q;
  assign pc_o              = pc_o_q;
  assign rd_addr_o         = rd_o_q;
  assign rd_data_o         = data_o_q;
  assign misaligned_o      = mis_q & valid_q;
  assign hz_rd_addr_o      = (!idle || valid_q) ? rd_q : 5'd0;
  assign hz_load_pending_o = (state_q == REQ) || (state_q == RESP);

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  logic        clk = 1'b0, rst = 1'b1;
  logic        ready_o, valid_i = 1'b0;
  logic [29:0] pc_i = '0;
  logic [4:0]  rd_addr_i = '0;
  logic [31:0] alu_result_i = '0, store_data_i = '0;
  logic        mem_en_i = 1'b0, mem_we_i = 1'b0, mem_unsigned_i = 1'b0;
  logic [1:0]  mem_size_i = '0;
  logic        dbus_req_o, dbus_we_o;
  logic [29:0] dbus_addr_o;
  logic [3:0]  dbus_be_o;
  logic [31:0] dbus_wdata_o;
  logic        gnt = 1'b0, rv_auto = 1'b0, rv_man = 1'b0;
  logic [31:0] bus_rdata = '0;
  wire         dbus_rvalid_i = rv_auto | rv_man;
  logic        valid_o, ready_i = 1'b1;
  logic [29:0] pc_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_o;
  logic        misaligned_o, hz_load_pending_o;
  logic [4:0]  hz_rd_addr_o;

  riscv_lsu dut (
    .clk_i(clk), .reset_i(rst), .ready_o(ready_o), .valid_i(valid_i),
    .pc_i(pc_i), .rd_addr_i(rd_addr_i), .alu_result_i(alu_result_i),
    .store_data_i(store_data_i), .mem_en_i(mem_en_i), .mem_we_i(mem_we_i),
    .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
    .dbus_req_o(dbus_req_o), .dbus_addr_o(dbus_addr_o), .dbus_we_o(dbus_we_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o), .dbus_gnt_i(gnt),
    .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(bus_rdata),
    .valid_o(valid_o), .ready_i(ready_i), .pc_o(pc_o), .rd_addr_o(rd_addr_o),
    .rd_data_o(rd_data_o), .misaligned_o(misaligned_o),
    .hz_rd_addr_o(hz_rd_addr_o), .hz_load_pending_o(hz_load_pending_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr; logic we; logic [3:0] be; logic [31:0] wdata, rdata;
  } bus_t;
  typedef struct {
    logic [29:0] pc; logic [4:0] rd; logic [31:0] data; logic mis; logic chk_data;
  } out_t;

  bus_t bus_q[$];
  out_t exp_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int gnt_dly = 0, req_cnt = 0, last_req_cycles = 0;
  logic rv_hold = 1'b0, pend_load = 1'b0;
  logic [31:0] pend_rdata = '0, last_data = '0;
  logic [4:0]  last_rd = '0, last_out_rd = '0;
  logic        last_mis = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (byte-lane arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction
  function automatic logic m_mis(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction
  function automatic logic [3:0] m_be(input logic [31:0] a, input logic [1:0] sz);
    logic [3:0] be = '0;
    int off = a % 4;
    for (int i = 0; i < 4; i++) be[i] = (i >= off) && (i < off + nbytes(sz));
    return be;
  endfunction
  function automatic logic [31:0] m_wdata(input logic [31:0] sd, input logic [1:0] sz);
    logic [31:0] w;
    int n = nbytes(sz);
    for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % n) +: 8];
    return w;
  endfunction
  function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                         input logic [1:0] sz, input logic uns);
    logic [31:0] v = rd >> (8 * (a % 4));
    if (nbytes(sz) == 1) begin
      v = v & 32'hFF;
      if (!uns && v[7]) v = v | 32'hFFFF_FF00;
    end else if (nbytes(sz) == 2) begin
      v = v & 32'hFFFF;
      if (!uns && v[15]) v = v | 32'hFFFF_0000;
    end
    return v;
  endfunction

  // ------------- compare process + bus responder (negedge) -----------------
  out_t o; bus_t b; logic pend;
  always @(negedge clk) begin
    if (rst) begin
      bus_q.delete(); exp_q.delete();
      pend_load = 1'b0; req_cnt = 0;
      gnt <= 1'b0; rv_auto <= 1'b0;
    end else begin
      pend = (bus_q.size() > 0) || pend_load;
      chk("dbus_req", dbus_req_o, bus_q.size() > 0);
      chk("hz_load_pending", hz_load_pending_o, pend);
      chk("valid_o", valid_o, (exp_q.size() > 0) && !pend);
      chk("hz_rd_addr", hz_rd_addr_o, (exp_q.size() > 0) ? last_rd : 5'd0);
      if (valid_o && ready_i === 1'b0) chk("ready_o_hold", ready_o, 1'b0);
      if (valid_o && exp_q.size() > 0) begin
        o = exp_q[0];
        chk("pc_o", pc_o, o.pc);
        chk("rd_addr_o", rd_addr_o, o.rd);
        if (o.chk_data) chk("rd_data_o", rd_data_o, o.data);
        chk("misaligned_o", misaligned_o, o.mis);
        if (ready_i) begin
          last_data = rd_data_o; last_out_rd = rd_addr_o; last_mis = misaligned_o;
          void'(exp_q.pop_front());
        end
      end
      rv_auto <= 1'b0;
      if (pend_load && !rv_hold) begin
        rv_auto <= 1'b1; bus_rdata <= pend_rdata; pend_load = 1'b0;
      end
      gnt <= 1'b0;
      if (dbus_req_o && bus_q.size() > 0) begin
        b = bus_q[0];
        chk("dbus_addr", dbus_addr_o, b.addr);
        chk("dbus_we", dbus_we_o, b.we);
        chk("dbus_be", dbus_be_o, b.be);
        chk("dbus_wdata", dbus_wdata_o, b.wdata);
        req_cnt++;
        if (req_cnt > gnt_dly) begin
          gnt <= 1'b1;
          last_req_cycles = req_cnt; req_cnt = 0;
          if (!b.we) begin pend_load = 1'b1; pend_rdata = b.rdata; end
          void'(bus_q.pop_front());
        end
      end
    end
  end

  // ---------------------------- driver -------------------------------------
  task automatic issue(input logic [29:0] pc, input logic [4:0] rd, input logic [31:0] alu,
                       input logic [31:0] sd, input logic en, input logic we,
                       input logic [1:0] sz, input logic uns, input logic [31:0] rdata);
    bit ok = 0;
    out_t eo; bus_t eb;
    pc_i = pc; rd_addr_i = rd; alu_result_i = alu; store_data_i = sd;
    mem_en_i = en; mem_we_i = we; mem_size_i = sz; mem_unsigned_i = uns;
    valid_i = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge clk);
      if (ready_o) begin @(posedge clk); ok = 1; end
    end
    #1 valid_i = 1'b0;
    if (!ok) begin
      tests++; fails++;
      $display("FAIL issue_timeout: got ready_o=0 expected 1 within 100 cycles");
    end else begin
      last_rd = rd;
      eo.pc = pc; eo.mis = 1'b0; eo.chk_data = 1'b1;
      if (!en) begin eo.rd = rd; eo.data = alu; end
      else if (m_mis(alu, sz)) begin eo.rd = 5'd0; eo.data = 32'h0; eo.mis = 1'b1; end
      else begin
        eb.addr = alu[31:2]; eb.we = we; eb.be = m_be(alu, sz);
        eb.wdata = we ? m_wdata(sd, sz) : 32'h0; eb.rdata = rdata;
        bus_q.push_back(eb);
        if (we) begin eo.rd = 5'd0; eo.data = 32'h0; eo.chk_data = 1'b0; end
        else begin eo.rd = rd; eo.data = m_load(rdata, alu, sz, uns); end
      end
      exp_q.push_back(eo);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int start;
  initial begin
    // model pins
    chk("model_be_sb", m_be(32'h1003, 2'd0), 4'b1000);
    chk("model_wdata_sb", m_wdata(32'hAB, 2'd0), 32'hABABABAB);
    chk("model_lh", m_load(32'h8001_0000, 32'h2002, 2'd1, 1'b0), 32'hFFFF8001);
    chk("model_lhu", m_load(32'h8001_0000, 32'h2002, 2'd1, 1'b1), 32'h00008001);
    chk("model_mis_lw", m_mis(32'h3001, 2'd2), 1'b1);

    // reset state
    @(posedge clk); #1;
    chk("rst_valid", valid_o, 0); chk("rst_req", dbus_req_o, 0);
    chk("rst_mis", misaligned_o, 0); chk("rst_hz_pend", hz_load_pending_o, 0);
    chk("rst_hz_rd", hz_rd_addr_o, 0);
    wait_cyc(1); rst = 1'b0; wait_cyc(1);

    // non-mem, then three back-to-back
    issue(30'd1, 5'd5, 32'h1234, 0, 0, 0, 0, 0, 0);
    wait_cyc(2);
    chk("nonmem_data", last_data, 32'h1234); chk("nonmem_rd", last_out_rd, 5);
    start = cyc;
    issue(30'd2, 5'd6, 32'h55, 0, 0, 0, 0, 0, 0);
    issue(30'd3, 5'd7, 32'h66, 0, 0, 0, 0, 0, 0);
    issue(30'd4, 5'd8, 32'h77, 0, 0, 0, 0, 0, 0);
    chk("throughput", cyc - start, 3);
    wait_cyc(2);

    // SB with two grant stalls, then SH/SW
    gnt_dly = 2;
    issue(30'd10, 5'd0, 32'h1003, 32'hAB, 1, 1, 2'd0, 0, 0);
    wait_cyc(6);
    chk("sb_req_cycles", last_req_cycles, 3); chk("sb_rd", last_out_rd, 0);
    gnt_dly = 0;
    issue(30'd11, 5'd0, 32'h1002, 32'h1234_5678, 1, 1, 2'd1, 0, 0);
    issue(30'd12, 5'd0, 32'h1004, 32'hCAFE_F00D, 1, 1, 2'd2, 0, 0);
    wait_cyc(4);

    // loads
    issue(30'd20, 5'd3, 32'h2002, 0, 1, 0, 2'd1, 0, 32'h8001_0000);
    wait_cyc(4); chk("lh_data", last_data, 32'hFFFF8001);
    issue(30'd21, 5'd3, 32'h2002, 0, 1, 0, 2'd1, 1, 32'h8001_0000);
    wait_cyc(4); chk("lhu_data", last_data, 32'h00008001);
    issue(30'd22, 5'd3, 32'h1001, 0, 1, 0, 2'd0, 0, 32'h0000_7F00);
    wait_cyc(4); chk("lb_data", last_data, 32'h0000007F);

    // misaligned word load
    issue(30'd30, 5'd9, 32'h3001, 0, 1, 0, 2'd2, 0, 0);
    wait_cyc(2); chk("mis_flag", last_mis, 1); chk("mis_rd", last_out_rd, 0);

    // load completes while WBU stalls
    ready_i = 1'b0;
    issue(30'd40, 5'd7, 32'h4000, 0, 1, 0, 2'd2, 0, 32'hDEAD_BEEF);
    chk("hold_pend_req", hz_load_pending_o, 1);
    for (int k = 0; k < 20 && !valid_o; k++) wait_cyc(1);
    repeat (4) begin
      @(negedge clk);
      chk("hold_ready", ready_o, 0); chk("hold_hz_rd", hz_rd_addr_o, 7);
      chk("hold_data", rd_data_o, 32'hDEAD_BEEF); chk("hold_pend", hz_load_pending_o, 0);
    end
    @(posedge clk); #1 ready_i = 1'b1;
    wait_cyc(2);

    // reset while waiting for rvalid
    rv_hold = 1'b1;
    issue(30'd50, 5'd4, 32'h5000, 0, 1, 0, 2'd2, 0, 32'h1111_1111);
    wait_cyc(1);
    chk("resp_pend", hz_load_pending_o, 1); chk("resp_hz_rd", hz_rd_addr_o, 4);
    rst = 1'b1; #1;
    chk("mid_rst_req", dbus_req_o, 0); chk("mid_rst_valid", valid_o, 0);
    chk("mid_rst_pend", hz_load_pending_o, 0); chk("mid_rst_hz_rd", hz_rd_addr_o, 0);
    wait_cyc(1); rst = 1'b0; rv_hold = 1'b0; rv_man = 1'b1;
    wait_cyc(1); rv_man = 1'b0;
    wait_cyc(2); chk("late_rvalid_ignored", valid_o, 0);
    issue(30'd60, 5'd2, 32'h6003, 0, 1, 0, 2'd0, 1, 32'h8000_0000);
    wait_cyc(4); chk("lbu_after_rst", last_data, 32'h00000080);
    issue(30'd61, 5'd2, 32'h6003, 0, 1, 0, 2'd0, 0, 32'h8000_0000);
    wait_cyc(4); chk("lb_after_rst", last_data, 32'hFFFFFF80);

    for (int k = 0; k < 50 && (exp_q.size() > 0 || bus_q.size() > 0); k++) wait_cyc(1);
    chk("drain", exp_q.size() + bus_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/riscv_lsu.md
Name: riscv_lsu

Overview:
Memory stage of the riscv pipeline, between the execute unit (EXU) and the write-back unit (WBU). It accepts one instruction at a time from the EXU over a valid/ready handshake. Loads and stores go to the data bus through a request/grant/response protocol; all other instructions pass through. Each completed instruction is presented to the WBU as pc, rd_addr and rd_data through a one-entry output register.

Parameters:
none

Ports:
clk_i  in  1  clock
reset_i  in  1  asynchronous, active-high reset
ready_o  out  1  EXU handshake: stage can accept
valid_i  in  1  EXU handshake: instruction valid
pc_i  in  30  word pc
rd_addr_i  in  5  destination register, 0 = none
alu_result_i  in  32  result (non-mem) or effective address (mem)
store_data_i  in  32  rs2 value for stores
mem_en_i  in  1  instruction is load or store
mem_we_i  in  1  1 = store, 0 = load
mem_size_i  in  2  0 = byte, 1 = half, 2 = word (3 reserved, treated as word)
mem_unsigned_i  in  1  zero-extend load (LBU/LHU)
dbus_req_o  out  1  bus request
dbus_addr_o  out  30  word address
dbus_we_o  out  1  write
dbus_be_o  out  4  byte enables
dbus_wdata_o  out  32  write data
dbus_gnt_i  in  1  request accepted
dbus_rvalid_i  in  1  read data valid (loads only)
dbus_rdata_i  in  32  read data
valid_o  out  1  WBU handshake: result valid
ready_i  in  1  WBU handshake: WBU accepts
pc_o  out  30  pc of result
rd_addr_o  out  5  destination
rd_data_o  out  32  write-back data
misaligned_o  out  1  qualifies valid_o: access was misaligned, not issued
hz_rd_addr_o  out  5  rd of the instruction held in this stage, else 0
hz_load_pending_o  out  1  load data not yet available

Behaviour:
- Reset (async, reset_i=1): state=IDLE.
  - Outputs: valid_o=0, dbus_req_o=0, misaligned_o=0, hz_load_pending_o=0, hz_rd_addr_o=0.
  - All data registers cleared to 0.
- States:
  - IDLE: no access outstanding.
  - REQ: dbus_req_o=1; address, we, be and wdata held stable until grant.
  - RESP: waiting for dbus_rvalid_i.
- Input handshake:
  - ready_o = (state==IDLE) && (!valid_o || ready_i).
  - Transfer occurs when valid_i && ready_o. Output register drains in the same cycle when valid_o && ready_i.
- Non-mem instruction: next cycle valid_o=1 with rd_data=alu_result, misaligned_o=0 (latency 1).
- Misalignment rule: half access with addr[0]=1, or word access with addr[1:0]!=0.
- Misaligned mem access:
  - No bus request is issued.
  - Next cycle: valid_o=1, misaligned_o=1, rd_addr_o=0, rd_data_o=0.
- Aligned mem access: capture the transaction and go to REQ next cycle.
  - dbus_addr_o = addr[31:2].
  - Store byte: be = 4'b0001 << addr[1:0]; wdata = byte replicated x4.
  - Store half: be = 4'b0011 << addr[1:0]; wdata = half replicated x2.
  - Store word: be = 4'hF; wdata = store_data.
  - Loads: dbus_we_o=0, be as for the same-size store, wdata=0.
- REQ + dbus_gnt_i:
  - Store: complete. Next cycle valid_o=1, rd_addr_o=0, state=IDLE.
  - Load: state=RESP.
- RESP + dbus_rvalid_i:
  - Extract byte/half at offset addr[1:0]; sign- or zero-extend per mem_unsigned.
  - Next cycle valid_o=1, rd_data_o=formatted data, state=IDLE.
- Bus rules:
  - dbus_rvalid_i outside RESP is ignored.
  - dbus_gnt_i outside REQ is ignored.
  - Minimum load latency, accept to valid_o: 3 cycles (gnt in the first REQ cycle, rvalid the following cycle).
- Output register holding:
  - Holds (valid_o and all payload outputs stable) while valid_o && !ready_i.
  - Never overwritten while valid. REQ/RESP are only entered with the output register free, so completion always lands in an empty register.
- Hazards:
  - hz_rd_addr_o = captured rd while state!=IDLE or valid_o, else 0.
  - hz_load_pending_o = (state==REQ || state==RESP).
- Reset mid-transaction: dbus_req_o drops immediately; a response arriving after reset is ignored.

Decomposition:
- riscv_pkg holds:
  - mem_size_e (MEM_BYTE=0, MEM_HALF=1, MEM_WORD=2).
  - lsu_state_e (IDLE, REQ, RESP).
- One combinational sub-module, riscv_lsu_align:
  - Inputs: size, offset, unsigned, store_data, rdata.
  - Outputs: be, wdata, load_data, misaligned.
  - Instantiated once; shared by the store and load paths.

Test Plan:
- Non-mem, rd=5, alu=0x1234, ready_i=1 -> valid_o next cycle, rd_data_o=0x1234, ready_o stays 1, back-to-back throughput 1/cycle.
- SB addr=0x1003 data=0xAB, gnt after 2 stall cycles -> dbus_req_o held 3 cycles with addr=0x400, be=4'b1000, wdata=0xABABABAB; then valid_o with rd_addr_o=0.
- LH addr=0x2002, rdata=0x8001_0000, signed -> rd_data_o=0xFFFF8001; LHU -> 0x00008001; LB offset 1 of 0x0000_7F00 -> 0x7F.
- LW addr=0x3001 -> no dbus_req_o, valid_o next cycle with misaligned_o=1, rd_addr_o=0.
- Load rd=7 completes while ready_i=0 for 4 cycles -> outputs stable, ready_o=0, hz_rd_addr_o=7; hz_load_pending_o=1 only in REQ/RESP.
- reset_i asserted while in RESP -> dbus_req_o, valid_o, hz outputs 0 at once; later rvalid ignored; next load executes normally.
